rpn_core: RTL and testbench

RPN_CORE -- requirements
Module: rpn_core

---
 rtl/rpn_core.sv | 340 ++++++++++++++++++++++++++++++++++
 tb/tb_rpn_core.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rpn_core.sv
// rpn_core
//   Reverse-Polish stack calculator core. Commands arrive on a valid/ready
//   handshake; the stack lives in a synchronous single-port RAM, and the
//   top-of-stack entry is held in a register so that `top` comes straight
//   from a flop.
//
//   Optional feature: define RPN_CORE_DIV_EN to build the iterative
//   1-bit/cycle restoring divider used by DIV and MOD. Without it, the
//   divide and remainder opcodes are rejected as illegal.
//
// Parameters
//   DATA_W    operand / stack word width (>= 16)
//   DEPTH     number of stack entries (power of two, >= 4)
//
// Ports
//   clk       clock, all state changes on the rising edge
//   rst       asynchronous active-high reset
//   cmd_valid command offered
//   cmd_ready command accepted when cmd_valid && cmd_ready (high only in IDLE)
//   cmd_op    opcode: 0 PUSH, 1 APPEND, 2 ADD, 3 SUB, 4 MUL, 5 DIV, 6 MOD,
//             7 DROP, 8 DUP, 9 SWAP, 10 CLEAR, 11-15 illegal
//   cmd_data  operand for PUSH / APPEND
//   top       current top of stack, 0 when empty
//   depth     number of valid entries
//   empty     depth == 0
//   full      depth == DEPTH
//   error     result of the last completed command
//   busy      multi-cycle operation in progress (== !cmd_ready)
module rpn_core #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 512
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [3:0]               cmd_op,
  input  logic [DATA_W-1:0]        cmd_data,
  output logic [DATA_W-1:0]        top,
  output logic [$clog2(DEPTH):0]   depth,
  output logic                     empty,
  output logic                     full,
  output logic                     error,
  output logic                     busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] D_ONE    = CW'(1);
  localparam logic [CW-1:0] D_TWO    = CW'(2);
  localparam logic [CW-1:0] D_FULLM1 = CW'(DEPTH - 1);
  localparam logic [AW-1:0] A_ONE    = AW'(1);
  localparam logic [AW-1:0] A_THREE  = AW'(3);

  localparam logic [3:0] OP_PUSH   = 4'd0;
  localparam logic [3:0] OP_APPEND = 4'd1;
  localparam logic [3:0] OP_ADD    = 4'd2;
  localparam logic [3:0] OP_SUB    = 4'd3;
  localparam logic [3:0] OP_MUL    = 4'd4;
`ifdef RPN_CORE_DIV_EN
  localparam logic [3:0] OP_DIV    = 4'd5;
  localparam logic [3:0] OP_MOD    = 4'd6;
`endif
  localparam logic [3:0] OP_DROP   = 4'd7;
  localparam logic [3:0] OP_DUP    = 4'd8;
  localparam logic [3:0] OP_SWAP   = 4'd9;
  localparam logic [3:0] OP_CLEAR  = 4'd10;

`ifdef RPN_CORE_DIV_EN
  typedef enum logic [1:0] {IDLE, EXEC, DIV_RUN, WB} state_t;

  localparam int CNTW = $clog2(DATA_W);
  localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(DATA_W - 1);
`else
  typedef enum logic {IDLE, EXEC} state_t;
`endif

  state_t              state;
  logic                rdy_q;
  logic [DATA_W-1:0]   top_q;
  logic [CW-1:0]       depth_q;
  logic                empty_q;
  logic                full_q;
  logic                err_q;

  // RAM port address register. It always points at the entry just below
  // the top (depth-2), so that entry is readable in the cycle a command is
  // accepted. Every write targets the same slot that becomes the new
  // below-top entry, so the one port serves both purposes.
  logic [AW-1:0]       addr_q;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [DATA_W-1:0]   rd_data;
  logic                mem_we;
  logic [AW-1:0]       mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;

  // Operand capture for the two-cycle arithmetic / SWAP path
  logic [DATA_W-1:0]   op_a;
  logic [DATA_W-1:0]   op_b;
  logic [3:0]          op_kind;
  logic [DATA_W-1:0]   exec_result;

  logic [CW-1:0]       depth_inc;
  logic [CW-1:0]       depth_dec;
  logic [AW-1:0]       addr_push;
  logic [AW-1:0]       addr_pop;
  logic                has_two;
  logic                is_one;
  logic                near_full;

`ifdef RPN_CORE_DIV_EN
  logic [DATA_W-1:0]   rem_q;
  logic [DATA_W-1:0]   quo_q;
  logic [CNTW-1:0]     cnt_q;
  logic                is_mod_q;
  logic [DATA_W:0]     rem_shift;
  logic [DATA_W:0]     rem_diff;
`endif

  assign rd_data   = mem[addr_q];
  assign depth_inc = depth_q + D_ONE;
  assign depth_dec = depth_q - D_ONE;
  // Below-top slot after a push (new depth d+1 -> slot d-1) and after a
  // pop (new depth d-1 -> slot d-3)
  assign addr_push = depth_q[AW-1:0] - A_ONE;
  assign addr_pop  = depth_q[AW-1:0] - A_THREE;
  assign has_two   = (depth_q >= D_TWO);
  assign is_one    = (depth_q == D_ONE);
  assign near_full = (depth_q == D_FULLM1);

`ifdef RPN_CORE_DIV_EN
  // One restoring-division step: shift the next dividend bit into the
  // partial remainder and try subtracting the divisor. A set MSB on the
  // difference means the trial went negative and the remainder is kept.
  assign rem_shift = {rem_q, quo_q[DATA_W-1]};
  assign rem_diff  = rem_shift - {1'b0, op_b};
`endif

  always_comb begin
    exec_result = op_a + op_b;
    case (op_kind)
      OP_SUB:  exec_result = op_a - op_b;
      OP_MUL:  exec_result = op_a * op_b;
      OP_SWAP: exec_result = op_a;
      default: exec_result = op_a + op_b;
    endcase
  end

  // RAM write decode. PUSH/DUP spill the cached top into the RAM (only
  // when there is a cached top to spill and room for it); SWAP writes the
  // old top into the below-top slot on its completion cycle.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = addr_push;
    mem_wdata = top_q;
    if (state == IDLE && cmd_valid && !empty_q && !full_q &&
        (cmd_op == OP_PUSH || cmd_op == OP_DUP)) begin
      mem_we = 1'b1;
    end
    if (state == EXEC && op_kind == OP_SWAP) begin
      mem_we    = 1'b1;
      mem_waddr = addr_q;
      mem_wdata = op_b;
    end
  end

  // Stack storage has no reset; its contents are don't-care after rst.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Control FSM and all architectural state. Visible outputs change only
  // on the completing edge of a command.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      rdy_q    <= 1'b1;
      top_q    <= '0;
      depth_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      err_q    <= 1'b0;
      addr_q   <= '0;
      op_a     <= '0;
      op_b     <= '0;
      op_kind  <= '0;
`ifdef RPN_CORE_DIV_EN
      rem_q    <= '0;
      quo_q    <= '0;
      cnt_q    <= '0;
      is_mod_q <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            case (cmd_op)
              OP_PUSH: begin
                if (full_q) begin
                  err_q <= 1'b1;
                end else begin
                  top_q   <= cmd_data;
                  depth_q <= depth_inc;
                  empty_q <= 1'b0;
                  full_q  <= near_full;
                  addr_q  <= addr_push;
                  err_q   <= 1'b0;
                end
              end
              OP_APPEND: begin
                if (empty_q) begin
                  err_q <= 1'b1;
                end else begin
                  top_q <= {top_q[DATA_W-9:0], cmd_data[7:0]};
                  err_q <= 1'b0;
                end
              end
              OP_ADD, OP_SUB, OP_MUL, OP_SWAP: begin
                if (!has_two) begin
                  err_q <= 1'b1;
                end else begin
                  op_a    <= rd_data;
                  op_b    <= top_q;
                  op_kind <= cmd_op;
                  state   <= EXEC;
                  rdy_q   <= 1'b0;
                end
              end
`ifdef RPN_CORE_DIV_EN
              OP_DIV, OP_MOD: begin
                if (!has_two || top_q == '0) begin
                  err_q <= 1'b1;
                end else begin
                  rem_q    <= '0;
                  quo_q    <= rd_data;
                  op_b     <= top_q;
                  is_mod_q <= (cmd_op == OP_MOD);
                  cnt_q    <= '0;
                  state    <= DIV_RUN;
                  rdy_q    <= 1'b0;
                end
              end
`endif
              OP_DROP: begin
                if (empty_q) begin
                  err_q <= 1'b1;
                end else begin
                  top_q   <= is_one ? '0 : rd_data;
                  depth_q <= depth_dec;
                  empty_q <= is_one;
                  full_q  <= 1'b0;
                  addr_q  <= addr_pop;
                  err_q   <= 1'b0;
                end
              end
              OP_DUP: begin
                if (empty_q || full_q) begin
                  err_q <= 1'b1;
                end else begin
                  depth_q <= depth_inc;
                  full_q  <= near_full;
                  addr_q  <= addr_push;
                  err_q   <= 1'b0;
                end
              end
              OP_CLEAR: begin
                top_q   <= '0;
                depth_q <= '0;
                empty_q <= 1'b1;
                full_q  <= 1'b0;
                err_q   <= 1'b0;
              end
              default: begin
                err_q <= 1'b1;
              end
            endcase
          end
        end

        // Second cycle of ADD/SUB/MUL/SWAP. Arithmetic ops shrink the
        // stack by one; SWAP keeps the depth and the below-top pointer.
        EXEC: begin
          top_q <= exec_result;
          if (op_kind != OP_SWAP) begin
            depth_q <= depth_dec;
            full_q  <= 1'b0;
            addr_q  <= addr_pop;
          end
          err_q <= 1'b0;
          state <= IDLE;
          rdy_q <= 1'b1;
        end

`ifdef RPN_CORE_DIV_EN
        DIV_RUN: begin
          if (rem_diff[DATA_W]) begin
            rem_q <= rem_shift[DATA_W-1:0];
            quo_q <= {quo_q[DATA_W-2:0], 1'b0};
          end else begin
            rem_q <= rem_diff[DATA_W-1:0];
            quo_q <= {quo_q[DATA_W-2:0], 1'b1};
          end
          cnt_q <= cnt_q + CNT_ONE;
          if (cnt_q == CNT_LAST) begin
            state <= WB;
          end
        end

        WB: begin
          top_q   <= is_mod_q ? rem_q : quo_q;
          depth_q <= depth_dec;
          full_q  <= 1'b0;
          addr_q  <= addr_pop;
          err_q   <= 1'b0;
          state   <= IDLE;
          rdy_q   <= 1'b1;
        end
`endif

        default: begin
          state <= IDLE;
          rdy_q <= 1'b1;
        end
      endcase
    end
  end

  assign cmd_ready = rdy_q;
  assign busy      = ~rdy_q;
  assign top       = top_q;
  assign depth     = depth_q;
  assign empty     = empty_q;
  assign full      = full_q;
  assign error     = err_q;

endmodule

// File: tb/tb_rpn_core.sv
// tb_rpn_core
//   Self-checking bench for rpn_core (DATA_W=32, DEPTH=4). A queue-based
//   stack model predicts top/depth/flags/error and completion latency for
//   every command; directed scenarios are followed by random commands.
//   Follows RPN_CORE_DIV_EN so the model matches the build.
module tb_rpn_core;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int DW     = $clog2(DEPTH) + 1;

  localparam logic [3:0] OP_PUSH   = 4'd0;
  localparam logic [3:0] OP_APPEND = 4'd1;
  localparam logic [3:0] OP_ADD    = 4'd2;
  localparam logic [3:0] OP_SUB    = 4'd3;
  localparam logic [3:0] OP_MUL    = 4'd4;
  localparam logic [3:0] OP_DIV    = 4'd5;
  localparam logic [3:0] OP_MOD    = 4'd6;
  localparam logic [3:0] OP_DROP   = 4'd7;
  localparam logic [3:0] OP_DUP    = 4'd8;
  localparam logic [3:0] OP_SWAP   = 4'd9;
  localparam logic [3:0] OP_CLEAR  = 4'd10;

`ifdef RPN_CORE_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [3:0]        cmd_op;
  logic [DATA_W-1:0] cmd_data;
  logic [DATA_W-1:0] top;
  logic [DW-1:0]     depth;
  logic              empty;
  logic              full;
  logic              error;
  logic              busy;

  int checkCount = 0;
  int passCount  = 0;

  logic [DATA_W-1:0] stk[$];
  logic              expErr;

  always #5 clk = ~clk;

  rpn_core #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_data (cmd_data),
    .top      (top),
    .depth    (depth),
    .empty    (empty),
    .full     (full),
    .error    (error),
    .busy     (busy)
  );

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
  endtask

  function automatic logic [DATA_W-1:0] modelTop();
    if (stk.size() == 0) return '0;
    return stk[stk.size()-1];
  endfunction

  // Stack semantics from the command definitions: error leaves the stack
  // untouched; latency is 1, 2 or DATA_W+2 cycles from acceptance.
  task automatic modelOp(input logic [3:0] op, input logic [DATA_W-1:0] data,
                         output int expLat);
    logic [DATA_W-1:0] a, b, r;
    int n;
    n = stk.size();
    expLat = 1;
    expErr = 1'b1;
    case (op)
      OP_PUSH: if (n < DEPTH) begin stk.push_back(data); expErr = 1'b0; end
      OP_APPEND: if (n >= 1) begin
        a = stk[n-1];
        stk[n-1] = {a[DATA_W-9:0], data[7:0]};
        expErr = 1'b0;
      end
      OP_ADD, OP_SUB, OP_MUL, OP_SWAP: if (n >= 2) begin
        b = stk.pop_back();
        a = stk.pop_back();
        expLat = 2;
        expErr = 1'b0;
        if (op == OP_SWAP) begin
          stk.push_back(b);
          stk.push_back(a);
        end else begin
          if (op == OP_ADD) r = a + b;
          else if (op == OP_SUB) r = a - b;
          else r = a * b;
          stk.push_back(r);
        end
      end
      OP_DIV, OP_MOD: if (DIV_EN && n >= 2 && stk[n-1] != 0) begin
        b = stk.pop_back();
        a = stk.pop_back();
        r = (op == OP_DIV) ? a / b : a % b;
        stk.push_back(r);
        expLat = DATA_W + 2;
        expErr = 1'b0;
      end
      OP_DROP: if (n >= 1) begin void'(stk.pop_back()); expErr = 1'b0; end
      OP_DUP: if (n >= 1 && n < DEPTH) begin stk.push_back(stk[n-1]); expErr = 1'b0; end
      OP_CLEAR: begin stk.delete(); expErr = 1'b0; end
      default: expErr = 1'b1;
    endcase
  endtask

  // Issues one command at a negedge, keeps a bogus PUSH offered while the
  // core is busy (it must be ignored), measures the latency and checks
  // that outputs stay frozen until completion.
  task automatic applyStimulus(input logic [3:0] op, input logic [DATA_W-1:0] data,
                               input string tag);
    int expLat;
    int lat;
    int guard;
    logic [DATA_W-1:0] preTop;
    logic [DW-1:0] preDepth;
    logic preErr;
    logic holdOk;
    guard = 0;
    while (cmd_ready !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    checkOutput({tag, "_ready"}, cmd_ready, 1);
    modelOp(op, data, expLat);
    preTop = top;
    preDepth = depth;
    preErr = error;
    holdOk = 1'b1;
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_data = data;
    @(posedge clk);
    #1;
    cmd_op = OP_PUSH;
    cmd_data = $urandom;
    lat = 1;
    @(negedge clk);
    while (cmd_ready !== 1'b1 && lat < 100) begin
      if (top !== preTop || depth !== preDepth || error !== preErr) holdOk = 1'b0;
      lat++;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    checkOutput({tag, "_latency"}, lat, expLat);
    checkOutput({tag, "_hold"}, holdOk, 1);
    checkOutput({tag, "_top"}, top, modelTop());
    checkOutput({tag, "_depth"}, depth, stk.size());
    checkOutput({tag, "_error"}, error, expErr);
    checkOutput({tag, "_empty"}, empty, stk.size() == 0);
    checkOutput({tag, "_full"}, full, stk.size() == DEPTH);
    checkOutput({tag, "_busy"}, busy, 0);
  endtask

  function automatic logic [DATA_W-1:0] randData();
    case ($urandom_range(0, 3))
      0: return '0;
      1: return DATA_W'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [3:0] op;
    int r;
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_op = '0;
    cmd_data = '0;
    expErr = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_top", top, 0);
    checkOutput("reset_depth", depth, 0);
    checkOutput("reset_empty", empty, 1);
    checkOutput("reset_full", full, 0);
    checkOutput("reset_error", error, 0);
    checkOutput("reset_ready", cmd_ready, 1);
    checkOutput("reset_busy", busy, 0);

    applyStimulus(OP_PUSH, 7, "sub_push7");
    applyStimulus(OP_PUSH, 5, "sub_push5");
    applyStimulus(OP_SUB, 0, "sub");
    checkOutput("sub_value", top, 2);

    applyStimulus(OP_CLEAR, 0, "app_clear");
    applyStimulus(OP_PUSH, 32'h12, "app_push");
    applyStimulus(OP_APPEND, 32'h34, "app_34");
    applyStimulus(OP_APPEND, 32'hAB56, "app_56");
    checkOutput("append_value", top, 32'h123456);

    applyStimulus(OP_CLEAR, 0, "div_clear");
    applyStimulus(OP_PUSH, 100, "div_push100");
    applyStimulus(OP_PUSH, 7, "div_push7");
    applyStimulus(OP_DIV, 0, "div");
`ifdef RPN_CORE_DIV_EN
    checkOutput("div_value", top, 14);
`endif
    applyStimulus(OP_CLEAR, 0, "mod_clear");
    applyStimulus(OP_PUSH, 100, "mod_push100");
    applyStimulus(OP_PUSH, 7, "mod_push7");
    applyStimulus(OP_MOD, 0, "mod");
`ifdef RPN_CORE_DIV_EN
    checkOutput("mod_value", top, 2);
`endif

    applyStimulus(OP_CLEAR, 0, "dz_clear");
    applyStimulus(OP_PUSH, 9, "dz_push9");
    applyStimulus(OP_PUSH, 0, "dz_push0");
    applyStimulus(OP_DIV, 0, "dz_div");
    checkOutput("divzero_error", error, 1);
    applyStimulus(OP_DROP, 0, "dz_drop");
    checkOutput("divzero_drop_top", top, 9);

    applyStimulus(OP_CLEAR, 0, "full_clear");
    for (int i = 0; i < DEPTH; i++) applyStimulus(OP_PUSH, DATA_W'(i + 1), "full_push");
    checkOutput("full_flag", full, 1);
    applyStimulus(OP_PUSH, 99, "overflow_push");
    checkOutput("overflow_error", error, 1);
    applyStimulus(OP_DUP, 0, "overflow_dup");
    applyStimulus(OP_SWAP, 0, "full_swap");
    applyStimulus(OP_CLEAR, 0, "full_clear2");
    applyStimulus(OP_ADD, 0, "empty_add");
    checkOutput("underflow_error", error, 1);
    applyStimulus(OP_DROP, 0, "empty_drop");
    applyStimulus(OP_APPEND, 1, "empty_append");
    applyStimulus(4'd13, 0, "illegal");

    // Reset while a multi-cycle command is running
    applyStimulus(OP_PUSH, 100, "rst_push100");
    applyStimulus(OP_PUSH, 7, "rst_push7");
    cmd_valid = 1'b1;
    cmd_op = DIV_EN ? OP_DIV : OP_ADD;
    cmd_data = '0;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    checkOutput("rst_mid_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_async_depth", depth, 0);
    checkOutput("rst_async_top", top, 0);
    checkOutput("rst_async_ready", cmd_ready, 1);
    checkOutput("rst_async_busy", busy, 0);
    @(posedge clk);
    #1;
    checkOutput("rst_next_depth", depth, 0);
    checkOutput("rst_next_empty", empty, 1);
    checkOutput("rst_next_error", error, 0);
    @(negedge clk);
    rst = 1'b0;
    stk.delete();
    expErr = 1'b0;
    @(negedge clk);
    checkOutput("rst_release_ready", cmd_ready, 1);
    checkOutput("rst_release_top", top, 0);

    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 24);
      op = (r < 10) ? OP_PUSH : 4'(r - 9);
      applyStimulus(op, randData(), $sformatf("rand%0d_op%0d", i, op));
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
